// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: ALU operation codes and the forwarding-hit helper.
// The ID-stage decoder imports the same codes.
package ex_stage_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regAddr_t;
  typedef logic [4:0]  aluCode_t;

  localparam aluCode_t ALU_ADD  = 5'd0;
  localparam aluCode_t ALU_AND  = 5'd1;
  localparam aluCode_t ALU_XOR  = 5'd2;
  localparam aluCode_t ALU_OR   = 5'd3;
  localparam aluCode_t ALU_NOR  = 5'd4;
  localparam aluCode_t ALU_SUB  = 5'd5;
  localparam aluCode_t ALU_ANDI = 5'd6;
  localparam aluCode_t ALU_XORI = 5'd7;
  localparam aluCode_t ALU_ORI  = 5'd8;
  localparam aluCode_t ALU_SLL  = 5'd16;
  localparam aluCode_t ALU_SRL  = 5'd17;
  localparam aluCode_t ALU_SRA  = 5'd18;
  localparam aluCode_t ALU_SLT  = 5'd19;
  localparam aluCode_t ALU_SLTU = 5'd20;

  // A later-stage write hits a source read unless it targets $zero.
  function automatic logic fwdHit(logic regWrite, regAddr_t writeAddr, regAddr_t readAddr);
    return regWrite && (writeAddr != 5'd0) && (writeAddr == readAddr);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX register, the later pipeline stages and the EX stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic     RegDst_ex;
  aluCode_t ALUCode_ex;
  logic     ALUSrcA_ex;
  logic     ALUSrcB_ex;
  word_t    Imm_ex;
  word_t    Sa_ex;
  regAddr_t RsAddr_ex;
  regAddr_t RtAddr_ex;
  regAddr_t RdAddr_ex;
  word_t    RsData_ex;
  word_t    RtData_ex;
  word_t    RegWriteData_wb;
  word_t    ALUResult_mem;
  regAddr_t RegWriteAddr_wb;
  regAddr_t RegWriteAddr_mem;
  logic     RegWrite_wb;
  logic     RegWrite_mem;
  regAddr_t RegWriteAddr_ex;
  word_t    ALUResult_ex;
  word_t    MemWriteData_ex;
  word_t    ALU_A;
  word_t    ALU_B;

  modport slave (
    input  RegDst_ex, ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, Sa_ex,
    input  RsAddr_ex, RtAddr_ex, RdAddr_ex, RsData_ex, RtData_ex,
    input  RegWriteData_wb, ALUResult_mem, RegWriteAddr_wb, RegWriteAddr_mem,
    input  RegWrite_wb, RegWrite_mem,
    output RegWriteAddr_ex, ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B
  );

  modport master (
    output RegDst_ex, ALUCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, Sa_ex,
    output RsAddr_ex, RtAddr_ex, RdAddr_ex, RsData_ex, RtData_ex,
    output RegWriteData_wb, ALUResult_mem, RegWriteAddr_wb, RegWriteAddr_mem,
    output RegWrite_wb, RegWrite_mem,
    input  RegWriteAddr_ex, ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B
  );

endinterface

// File: rtl/ex_stage_alu.sv
// 32-bit combinational ALU; unknown operation codes produce zero.
module alu
  import ex_stage_pkg::*;
(
  input  aluCode_t ALUCode,
  input  word_t    A,
  input  word_t    B,
  output word_t    Result
);

  word_t bLow;
  assign bLow = {16'h0, B[15:0]};

  always_comb begin
    Result = '0;
    case (ALUCode)
      ALU_ADD:  Result = A + B;
      ALU_AND:  Result = A & B;
      ALU_XOR:  Result = A ^ B;
      ALU_OR:   Result = A | B;
      ALU_NOR:  Result = ~(A | B);
      ALU_SUB:  Result = A - B;
      ALU_ANDI: Result = A & bLow;
      ALU_XORI: Result = A ^ bLow;
      ALU_ORI:  Result = A | bLow;
      ALU_SLL:  Result = B << A[4:0];
      ALU_SRL:  Result = B >> A[4:0];
      ALU_SRA:  Result = $signed(B) >>> A[4:0];
      ALU_SLT:  Result = {31'h0, $signed(A) < $signed(B)};
      ALU_SLTU: Result = {31'h0, A < B};
      default:  Result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: MEM/WB forwarding, operand selection, destination select and ALU.
// Purely combinational; clk and reset are carried only for pipeline uniformity.
module ex_stage
  import ex_stage_pkg::*;
(
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave exIf
);

  logic unusedClkRst;
  assign unusedClkRst = clk ^ reset;

  word_t fwdA;
  word_t fwdB;

  // MEM holds the younger result, so it is checked before WB.
  always_comb begin
    fwdA = exIf.RsData_ex;
    if (fwdHit(exIf.RegWrite_mem, exIf.RegWriteAddr_mem, exIf.RsAddr_ex)) begin
      fwdA = exIf.ALUResult_mem;
    end else if (fwdHit(exIf.RegWrite_wb, exIf.RegWriteAddr_wb, exIf.RsAddr_ex)) begin
      fwdA = exIf.RegWriteData_wb;
    end

    fwdB = exIf.RtData_ex;
    if (fwdHit(exIf.RegWrite_mem, exIf.RegWriteAddr_mem, exIf.RtAddr_ex)) begin
      fwdB = exIf.ALUResult_mem;
    end else if (fwdHit(exIf.RegWrite_wb, exIf.RegWriteAddr_wb, exIf.RtAddr_ex)) begin
      fwdB = exIf.RegWriteData_wb;
    end
  end

  assign exIf.ALU_A           = exIf.ALUSrcA_ex ? exIf.Sa_ex  : fwdA;
  assign exIf.ALU_B           = exIf.ALUSrcB_ex ? exIf.Imm_ex : fwdB;
  assign exIf.MemWriteData_ex = fwdB;
  assign exIf.RegWriteAddr_ex = exIf.RegDst_ex ? exIf.RdAddr_ex : exIf.RtAddr_ex;

  alu uAlu (
    .ALUCode (exIf.ALUCode_ex),
    .A       (exIf.ALU_A),
    .B       (exIf.ALU_B),
    .Result  (exIf.ALUResult_ex)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, immediates, shifts, compares, forwarding, RegDst.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_stage_if exIf ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .exIf  (exIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    exIf.RegDst_ex        = 1'b0;
    exIf.ALUCode_ex       = ALU_ADD;
    exIf.ALUSrcA_ex       = 1'b0;
    exIf.ALUSrcB_ex       = 1'b0;
    exIf.Imm_ex           = '0;
    exIf.Sa_ex            = '0;
    exIf.RsAddr_ex        = 5'd1;
    exIf.RtAddr_ex        = 5'd2;
    exIf.RdAddr_ex        = 5'd3;
    exIf.RsData_ex        = '0;
    exIf.RtData_ex        = '0;
    exIf.RegWriteData_wb  = '0;
    exIf.ALUResult_mem    = '0;
    exIf.RegWriteAddr_wb  = '0;
    exIf.RegWriteAddr_mem = '0;
    exIf.RegWrite_wb      = 1'b0;
    exIf.RegWrite_mem     = 1'b0;
  endtask

  // Drive on the falling edge, sample 2 ns later, well clear of the rising edge.
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    exIf.RsData_ex = 32'h1234_5678;
    exIf.RtData_ex = 32'h0000_0001;
    @(negedge clk);
    settle();
    checks++;
    if (exIf.ALUResult_ex !== 32'h1234_5679) begin
      errors++;
      $display("FAIL reset_add: got %h, expected %h", exIf.ALUResult_ex, 32'h1234_5679);
    end
    checks++;
    if (exIf.RegWriteAddr_ex !== 5'd2) begin
      errors++;
      $display("FAIL reset_dst: got %0d, expected %0d", exIf.RegWriteAddr_ex, 2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    word_t a[2] = '{32'h0000_4012, 32'h4000_0000};
    word_t b[2] = '{32'h1000_200F, 32'h4000_0000};
    word_t e[2] = '{32'h1000_6021, 32'h8000_0000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      exIf.RsData_ex = a[i];
      exIf.RtData_ex = b[i];
      settle();
      checks++;
      if (exIf.ALUResult_ex !== e[i]) begin
        errors++;
        $display("FAIL add_%0d: got %h, expected %h", i, exIf.ALUResult_ex, e[i]);
      end
    end
  endtask

  task automatic test_logic();
    aluCode_t c[6] = '{ALU_AND, ALU_XOR, ALU_OR, ALU_NOR, 5'd9, 5'd31};
    word_t    e[6] = '{32'h100C_0010, 32'hEFD3_3EEF, 32'hFFDF_3EFF, 32'h0020_C100,
                       32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      exIf.ALUCode_ex = c[i];
      exIf.RsData_ex  = 32'hFF0C_0E10;
      exIf.RtData_ex  = 32'h10DF_30FF;
      settle();
      checks++;
      if (exIf.ALUResult_ex !== e[i]) begin
        errors++;
        $display("FAIL logic_code%0d: got %h, expected %h", c[i], exIf.ALUResult_ex, e[i]);
      end
    end
  endtask

  task automatic test_sub();
    @(negedge clk);
    clear_inputs();
    exIf.ALUCode_ex = ALU_SUB;
    exIf.RsData_ex  = 32'h70F0_C0E0;
    exIf.RtData_ex  = 32'h1000_3054;
    settle();
    checks++;
    if (exIf.ALUResult_ex !== 32'h60F0_908C) begin
      errors++;
      $display("FAIL sub: got %h, expected %h", exIf.ALUResult_ex, 32'h60F0_908C);
    end
  endtask

  task automatic test_imm();
    aluCode_t c[3] = '{ALU_ANDI, ALU_XORI, ALU_ORI};
    word_t    e[3] = '{32'h0000_0010, 32'hFF0C_EEEF, 32'hFF0C_EEFF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      exIf.ALUCode_ex = c[i];
      exIf.ALUSrcB_ex = 1'b1;
      exIf.Imm_ex     = 32'hFFFF_E0FF;
      exIf.RsData_ex  = 32'hFF0C_0E10;
      exIf.RtData_ex  = 32'h5A5A_5A5A;
      settle();
      checks++;
      if (exIf.ALUResult_ex !== e[i]) begin
        errors++;
        $display("FAIL imm_code%0d: got %h, expected %h", c[i], exIf.ALUResult_ex, e[i]);
      end
      checks++;
      if (exIf.ALU_B !== 32'hFFFF_E0FF) begin
        errors++;
        $display("FAIL imm_aluB: got %h, expected %h", exIf.ALU_B, 32'hFFFF_E0FF);
      end
    end
  endtask

  task automatic test_shift_cmp();
    // Sa of 0x24 exercises that only the low five bits set the shift distance.
    aluCode_t c[6]  = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA, ALU_SLT, ALU_SLTU};
    logic     sa[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    word_t    s[6]  = '{32'd4, 32'd4, 32'd4, 32'h24, 32'd0, 32'd0};
    word_t    a[6]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF00_0004, 32'hFF00_0004};
    word_t    b[6]  = '{32'hFFFF_E0FF, 32'hFFFF_E0FF, 32'hFFFF_E0FF, 32'hFFFF_E0FF,
                        32'h7000_00FF, 32'h7000_00FF};
    word_t    e[6]  = '{32'hFFFE_0FF0, 32'h0FFF_FE0F, 32'hFFFF_FE0F, 32'hFFFF_FE0F,
                        32'h0000_0001, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      exIf.ALUCode_ex = c[i];
      exIf.ALUSrcA_ex = sa[i];
      exIf.Sa_ex      = s[i];
      exIf.RsData_ex  = a[i];
      exIf.RtData_ex  = b[i];
      settle();
      checks++;
      if (exIf.ALUResult_ex !== e[i]) begin
        errors++;
        $display("FAIL shiftcmp_%0d: got %h, expected %h", i, exIf.ALUResult_ex, e[i]);
      end
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    clear_inputs();
    exIf.RsAddr_ex        = 5'd5;
    exIf.RtAddr_ex        = 5'd6;
    exIf.RsData_ex        = 32'h1111_1111;
    exIf.RtData_ex        = 32'h2222_2222;
    exIf.ALUResult_mem    = 32'hAAAA_AAAA;
    exIf.RegWriteData_wb  = 32'hBBBB_BBBB;
    exIf.RegWrite_mem     = 1'b1;
    exIf.RegWriteAddr_mem = 5'd5;
    exIf.RegWrite_wb      = 1'b1;
    exIf.RegWriteAddr_wb  = 5'd5;
    settle();
    checks++;
    if (exIf.ALU_A !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL fwd_mem_priority: got %h, expected %h", exIf.ALU_A, 32'hAAAA_AAAA);
    end
    checks++;
    if (exIf.ALUResult_ex !== 32'hCCCC_CCCC) begin
      errors++;
      $display("FAIL fwd_mem_result: got %h, expected %h", exIf.ALUResult_ex, 32'hCCCC_CCCC);
    end

    @(negedge clk);
    exIf.RegWrite_mem = 1'b0;
    settle();
    checks++;
    if (exIf.ALU_A !== 32'hBBBB_BBBB) begin
      errors++;
      $display("FAIL fwd_wb: got %h, expected %h", exIf.ALU_A, 32'hBBBB_BBBB);
    end

    @(negedge clk);
    exIf.RegWrite_mem     = 1'b1;
    exIf.RsAddr_ex        = 5'd0;
    exIf.RegWriteAddr_mem = 5'd0;
    exIf.RegWriteAddr_wb  = 5'd0;
    settle();
    checks++;
    if (exIf.ALU_A !== 32'h1111_1111) begin
      errors++;
      $display("FAIL fwd_zero_reg: got %h, expected %h", exIf.ALU_A, 32'h1111_1111);
    end

    // Rt hit in MEM while Imm feeds the ALU: store data must still be forwarded.
    @(negedge clk);
    exIf.RtAddr_ex        = 5'd7;
    exIf.RegWriteAddr_mem = 5'd7;
    exIf.RegWriteAddr_wb  = 5'd9;
    exIf.ALUSrcB_ex       = 1'b1;
    exIf.Imm_ex           = 32'h0000_0010;
    settle();
    checks++;
    if (exIf.MemWriteData_ex !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL fwd_store_mem: got %h, expected %h", exIf.MemWriteData_ex, 32'hAAAA_AAAA);
    end
    checks++;
    if (exIf.ALU_B !== 32'h0000_0010) begin
      errors++;
      $display("FAIL fwd_store_aluB: got %h, expected %h", exIf.ALU_B, 32'h0000_0010);
    end

    @(negedge clk);
    exIf.RegWrite_mem    = 1'b0;
    exIf.RegWriteAddr_wb = 5'd7;
    exIf.ALUSrcB_ex      = 1'b0;
    settle();
    checks++;
    if (exIf.ALU_B !== 32'hBBBB_BBBB) begin
      errors++;
      $display("FAIL fwd_rt_wb: got %h, expected %h", exIf.ALU_B, 32'hBBBB_BBBB);
    end
  endtask

  task automatic test_regdst();
    @(negedge clk);
    clear_inputs();
    exIf.RtAddr_ex = 5'd12;
    exIf.RdAddr_ex = 5'd27;
    exIf.RegDst_ex = 1'b1;
    settle();
    checks++;
    if (exIf.RegWriteAddr_ex !== 5'd27) begin
      errors++;
      $display("FAIL regdst_rd: got %0d, expected %0d", exIf.RegWriteAddr_ex, 27);
    end
    @(negedge clk);
    exIf.RegDst_ex = 1'b0;
    settle();
    checks++;
    if (exIf.RegWriteAddr_ex !== 5'd12) begin
      errors++;
      $display("FAIL regdst_rt: got %0d, expected %0d", exIf.RegWriteAddr_ex, 12);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_add();
    test_logic();
    test_sub();
    test_imm();
    test_shift_cmp();
    test_forward();
    test_regdst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined 32-bit MIPS CPU, between the ID/EX and EX/MEM pipeline registers. It resolves EX-stage data hazards by forwarding from MEM and WB, selects ALU operands, and computes the ALU result. It also selects the destination register address and produces the store data. The datapath is purely combinational; the stage holds no state.

## Interface
Parameters: none.
- clk  in  1  clock; one clock, shared with the pipeline; no internal state uses it
- reset  in  1  synchronous, active-high; no internal state, so no effect on outputs
- RegDst_ex  in  1  1: destination is Rd; 0: destination is Rt
- ALUCode_ex  in  5  ALU operation code
- ALUSrcA_ex  in  1  1: A = Sa_ex; 0: A = forwarded Rs
- ALUSrcB_ex  in  1  1: B = Imm_ex; 0: B = forwarded Rt
- Imm_ex  in  32  sign-extended immediate
- Sa_ex  in  32  zero-extended shift amount
- RsAddr_ex, RtAddr_ex, RdAddr_ex  in  5 each  register numbers
- RsData_ex, RtData_ex  in  32 each  register-file read data
- RegWriteData_wb  in  32  WB write-back data
- ALUResult_mem  in  32  MEM-stage ALU result
- RegWriteAddr_wb, RegWriteAddr_mem  in  5 each  destination registers in WB and MEM
- RegWrite_wb, RegWrite_mem  in  1 each  write enables in WB and MEM
- RegWriteAddr_ex  out  5  selected destination register
- ALUResult_ex  out  32  ALU result
- MemWriteData_ex  out  32  forwarded Rt (store data)
- ALU_A, ALU_B  out  32 each  actual ALU operands (debug/visibility)

## Operation
- Forward A (Rs):
  - If RegWrite_mem and RegWriteAddr_mem != 0 and RegWriteAddr_mem == RsAddr_ex: use ALUResult_mem.
  - Else if RegWrite_wb and RegWriteAddr_wb != 0 and RegWriteAddr_wb == RsAddr_ex: use RegWriteData_wb.
  - Else: use RsData_ex.
- Forward B (Rt): same rule applied to RtAddr_ex/RtData_ex.
- When both MEM and WB match, MEM wins.
- Register 0 is never forwarded.
- ALU_A = ALUSrcA_ex ? Sa_ex : fwdA.
- ALU_B = ALUSrcB_ex ? Imm_ex : fwdB.
- MemWriteData_ex = fwdB.
- RegWriteAddr_ex = RegDst_ex ? RdAddr_ex : RtAddr_ex.
- ALU codes (decimal):
  - 0 add: A+B, modulo 2^32, no overflow detection
  - 1 and: A&B
  - 2 xor: A^B
  - 3 or: A|B
  - 4 nor: ~(A|B)
  - 5 sub: A−B, modulo 2^32
  - 6 andi: A & {16'h0, B[15:0]}
  - 7 xori: A ^ {16'h0, B[15:0]}
  - 8 ori: A | {16'h0, B[15:0]}
  - 16 sll: B << A[4:0]
  - 17 srl: B >> A[4:0], logical
  - 18 sra: B >>> A[4:0], arithmetic
  - 19 slt: signed A<B → 32'd1, else 32'd0
  - 20 sltu: unsigned A<B → 32'd1, else 32'd0
  - any other code: result 32'h0
- Shift amount uses only A[4:0]; A[31:5] is ignored.

## Timing
- Fully combinational from every data/control input to every output. Zero-cycle latency; outputs settle within the same cycle.
- No handshakes and no state machine.
- reset and clk do not alter outputs. There is no reset value beyond the combinational function of the current inputs.
- Simultaneous MEM and WB hits on the same register: MEM data is selected.

## Structure
- Shared package holds the ALU code constants: ALU_ADD=0, AND=1, XOR=2, OR=3, NOR=4, SUB=5, ANDI=6, XORI=7, ORI=8, SLL=16, SRL=17, SRA=18, SLT=19, SLTU=20. The ID-stage decoder uses the same package.
- One sub-module, `alu`: inputs ALUCode, A, B; output Result.
- Forwarding muxes, operand muxes and the RegDst mux live in the top level.

## Test plan
- No forwarding (RegWrite_* = 0), ALUSrcA = ALUSrcB = 0, RsData = 32'h00004012, RtData = 32'h1000200F, code 0 → ALUResult 32'h10006021. 32'h40000000 + 32'h40000000 → 32'h80000000.
- Logic ops with A = FF0C0E10, B = 10DF30FF:
  - and → 100C0010
  - xor → EFD33EEF
  - or → FFDF3EFF
  - nor → 0020C100
- Subtract: 70F0C0E0 − 10003054 → 60F0908C.
- Logical immediates, ALUSrcB = 1, Imm = FFFFE0FF, A = FF0C0E10:
  - andi → 00000010
  - xori → FF0CEEEF
  - ori → FF0CEEFF
- Shifts and compares:
  - ALUSrcA = 1, Sa = 4, B = FFFFE0FF: sll → FFFE0FF0; srl → 0FFFFE0F; sra → FFFFFE0F
  - A = FF000004, B = 700000FF: slt → 00000001; sltu → 00000000
- Forwarding:
  - RsAddr = 5, RegWrite_mem = 1, RegWriteAddr_mem = 5, RegWrite_wb = 1, RegWriteAddr_wb = 5 → ALU_A = ALUResult_mem.
  - Drop RegWrite_mem → ALU_A = RegWriteData_wb.
  - Address 0 with both enables set → ALU_A = RsData.
  - Rt hit in MEM → MemWriteData_ex = ALUResult_mem.
  - RegDst = 1 → RegWriteAddr_ex = RdAddr; RegDst = 0 → RtAddr.
